stone_drawer: RTL and testbench

STONE_DRAWER -- requirements
Module: stone_drawer

---
 rtl/stone_drawer_if.sv | 24 ++
 rtl/stone_drawer.sv | 160 ++++++++++++++++
 tb/tb_stone_drawer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/stone_drawer_if.sv
// Bus between the stone drawer and its neighbours: stone RAM read port,
// pass control handshake and the VGA pixel stream.
interface stone_drawer_if;
    logic        start;
    logic [3:0]  quantity;
    logic [31:0] data;
    logic [3:0]  draw_index;
    logic        draw_stone_flag;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        done;

    modport master (
        output start, quantity, data,
        input  draw_index, draw_stone_flag, x, y, colour, plot, done
    );

    modport slave (
        input  start, quantity, data,
        output draw_index, draw_stone_flag, x, y, colour, plot, done
    );
endinterface

// File: rtl/stone_drawer.sv
// Walks the stone table once per start request and paints every visible stone
// as a SIZE x SIZE solid square, clipping pixels that fall off screen.
module stone_drawer #(
    parameter int SIZE         = 16,
    parameter int READ_LATENCY = 2,
    parameter int SCREEN_W     = 320,
    parameter int SCREEN_H     = 240
) (
    input logic            clock,
    input logic            resetn,
    stone_drawer_if.slave  bus
);
    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CW-1:0] LAST     = CW'(SIZE - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(READ_LATENCY - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] READ   = 3'd1;
    localparam logic [2:0] LATCH  = 3'd2;
    localparam logic [2:0] DRAW   = 3'd3;
    localparam logic [2:0] NEXT   = 3'd4;
    localparam logic [2:0] FINISH = 3'd5;

    logic [2:0]    state;
    logic [LW-1:0] lat_cnt;
    logic [CW-1:0] col, row;
    logic [8:0]    rec_x;
    logic [7:0]    rec_y;
    logic [1:0]    rec_type;

    logic [CW-1:0] next_col, next_row;
    logic [8:0]    base_x;
    logic [7:0]    base_y;
    logic [1:0]    base_type;
    logic [11:0]   sum_x, sum_y;
    logic          in_clip;
    logic [2:0]    type_colour;
    logic          last_pixel;
    logic [4:0]    index_next;
    logic          unused_bits;

    // Pixel for the coming cycle: in LATCH it is (0,0) of the record still on
    // the RAM bus, in DRAW the successor of the pixel currently presented.
    always_comb begin
        next_col  = '0;
        next_row  = '0;
        base_x    = rec_x;
        base_y    = rec_y;
        base_type = rec_type;
        if (state == LATCH) begin
            base_x    = bus.data[31:23];
            base_y    = bus.data[18:11];
            base_type = bus.data[3:2];
        end else if (col == LAST) begin
            next_row = row + 1'b1;
        end else begin
            next_col = col + 1'b1;
            next_row = row;
        end
        sum_x   = 12'(base_x) + 12'(next_col);
        sum_y   = 12'(base_y) + 12'(next_row);
        in_clip = (sum_x < 12'(SCREEN_W)) && (sum_y < 12'(SCREEN_H));
        case (base_type)
            2'b00:   type_colour = 3'b111;
            2'b01:   type_colour = 3'b110;
            default: type_colour = 3'b011;
        endcase
    end

    assign last_pixel  = (col == LAST) && (row == LAST);
    assign index_next  = {1'b0, bus.draw_index} + 5'd1;
    assign unused_bits = ^{bus.data[22:19], bus.data[10:4], bus.data[0],
                           sum_x[11:9], sum_y[11:8]};

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state               <= IDLE;
            lat_cnt             <= '0;
            col                 <= '0;
            row                 <= '0;
            rec_x               <= '0;
            rec_y               <= '0;
            rec_type            <= '0;
            bus.draw_index      <= '0;
            bus.draw_stone_flag <= 1'b0;
            bus.x               <= '0;
            bus.y               <= '0;
            bus.colour          <= '0;
            bus.plot            <= 1'b0;
            bus.done            <= 1'b0;
        end else begin
            bus.plot <= 1'b0;
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.draw_index <= '0;
                        lat_cnt        <= '0;
                        if (bus.quantity == 4'd0) begin
                            state    <= FINISH;
                            bus.done <= 1'b1;
                        end else begin
                            state               <= READ;
                            bus.draw_stone_flag <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (lat_cnt == LAT_LAST) begin
                        lat_cnt <= '0;
                        state   <= LATCH;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                LATCH: begin
                    rec_x    <= bus.data[31:23];
                    rec_y    <= bus.data[18:11];
                    rec_type <= bus.data[3:2];
                    col      <= '0;
                    row      <= '0;
                    if (bus.data[1]) begin
                        state      <= DRAW;
                        bus.x      <= sum_x[8:0];
                        bus.y      <= sum_y[7:0];
                        bus.colour <= type_colour;
                        bus.plot   <= in_clip;
                    end else begin
                        state <= NEXT;
                    end
                end
                // Clipped pixels still take their cycle so a stone always costs SIZE*SIZE.
                DRAW: begin
                    if (last_pixel) begin
                        state <= NEXT;
                    end else begin
                        col      <= next_col;
                        row      <= next_row;
                        bus.x    <= sum_x[8:0];
                        bus.y    <= sum_y[7:0];
                        bus.plot <= in_clip;
                    end
                end
                NEXT: begin
                    bus.draw_index <= index_next[3:0];
                    if (index_next >= {1'b0, bus.quantity}) begin
                        state               <= FINISH;
                        bus.draw_stone_flag <= 1'b0;
                        bus.done            <= 1'b1;
                    end else begin
                        state <= READ;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stone_drawer.sv
// Self-checking bench for stone_drawer: a cycle-exact expected trace is built
// from the drawing rules for every pass and compared on each falling edge.
module tb_stone_drawer;
    localparam int SIZE = 16;
    localparam int RL   = 2;
    localparam int SW   = 320;
    localparam int SH   = 240;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    stone_drawer_if bus();

    stone_drawer #(
        .SIZE(SIZE), .READ_LATENCY(RL), .SCREEN_W(SW), .SCREEN_H(SH)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 clock = ~clock;

    // Stone RAM with a two-register read path.
    logic [31:0] ram [16];
    logic [31:0] ram_p1;
    always @(posedge clock) begin
        ram_p1   <= ram[bus.draw_index];
        bus.data <= ram_p1;
    end

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int repulse_at = -1;
    int plots_seen, plots_model;
    logic [8:0] m_x      = '0;
    logic [7:0] m_y      = '0;
    logic [2:0] m_colour = '0;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s (cycle %0d): observed %0h expected %0h",
                   tag, cyc, observed, expected);
        end
    endtask

    task automatic check_cycle(input logic e_plot, input logic e_flag,
                               input logic e_done, input int e_idx);
        check_output("plot",   32'(bus.plot), 32'(e_plot));
        check_output("flag",   32'(bus.draw_stone_flag), 32'(e_flag));
        check_output("done",   32'(bus.done), 32'(e_done));
        check_output("x",      32'(bus.x), 32'(m_x));
        check_output("y",      32'(bus.y), 32'(m_y));
        check_output("colour", 32'(bus.colour), 32'(m_colour));
        if (e_idx >= 0) check_output("draw_index", 32'(bus.draw_index), 32'(e_idx));
        if (bus.plot === 1'b1) plots_seen++;
        if (e_plot) plots_model++;
    endtask

    task automatic tick();
        bus.start = (cyc == repulse_at);
        @(negedge clock);
        cyc++;
    endtask

    function automatic logic [2:0] colour_of(input logic [1:0] ty);
        case (ty)
            2'b00:   return 3'b111;
            2'b01:   return 3'b110;
            default: return 3'b011;
        endcase
    endfunction

    function automatic logic [31:0] make_rec(input int px, input int py, input int ty,
                                             input bit vis, input bit mov);
        logic [31:0] r;
        r = $urandom;
        r[31:23] = 9'(px);
        r[18:11] = 8'(py);
        r[3:2]   = 2'(ty);
        r[1]     = vis;
        r[0]     = mov;
        return r;
    endfunction

    // One full pass; reset_draw >= 0 pulls resetn low at that DRAW cycle of the first visible stone.
    task automatic apply_stimulus(input int q, input int repulse, input int reset_draw);
        logic [31:0] r;
        int sx, sy, draw_n;
        bus.quantity = 4'(q);
        repulse_at   = repulse;
        plots_seen   = 0;
        plots_model  = 0;
        draw_n       = 0;
        @(negedge clock);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        cyc = 1;
        for (int i = 0; i < q; i++) begin
            r = ram[i];
            for (int k = 0; k < RL; k++) begin
                check_cycle(1'b0, 1'b1, 1'b0, i);
                tick();
            end
            check_cycle(1'b0, 1'b1, 1'b0, i);
            tick();
            if (r[1]) begin
                for (int rw = 0; rw < SIZE; rw++) begin
                    for (int cl = 0; cl < SIZE; cl++) begin
                        sx = int'(r[31:23]) + cl;
                        sy = int'(r[18:11]) + rw;
                        m_x      = 9'(sx);
                        m_y      = 8'(sy);
                        m_colour = colour_of(r[3:2]);
                        check_cycle((sx < SW) && (sy < SH), 1'b1, 1'b0, i);
                        if (draw_n == reset_draw) begin
                            resetn    = 1'b0;
                            bus.start = 1'b0;
                            @(negedge clock);
                            cyc++;
                            m_x = '0;
                            m_y = '0;
                            m_colour = '0;
                            check_cycle(1'b0, 1'b0, 1'b0, 0);
                            resetn = 1'b1;
                            repulse_at = -1;
                            @(negedge clock);
                            check_cycle(1'b0, 1'b0, 1'b0, 0);
                            return;
                        end
                        draw_n++;
                        tick();
                    end
                end
            end
            check_cycle(1'b0, 1'b1, 1'b0, i);
            tick();
        end
        check_cycle(1'b0, 1'b0, 1'b1, -1);
        tick();
        check_cycle(1'b0, 1'b0, 1'b0, -1);
        bus.start  = 1'b0;
        repulse_at = -1;
        check_output("plot_count", 32'(plots_seen), 32'(plots_model));
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.quantity = 4'd0;
        for (int i = 0; i < 16; i++) ram[i] = $urandom;
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        check_cycle(1'b0, 1'b0, 1'b0, 0);
        resetn = 1'b1;
        @(negedge clock);
        check_cycle(1'b0, 1'b0, 1'b0, 0);

        $display("[TB] single gold stone at (100,50)");
        ram[0] = make_rec(100, 50, 1, 1'b1, 1'b0);
        apply_stimulus(1, -1, -1);
        check_output("gold_plots", 32'(plots_seen), 32'd256);
        check_output("gold_last_x", 32'(bus.x), 32'd115);
        check_output("gold_last_y", 32'(bus.y), 32'd65);

        $display("[TB] three stones, middle one invisible and moving");
        ram[0] = make_rec(20, 30, 0, 1'b1, 1'b1);
        ram[1] = make_rec(60, 70, 2, 1'b0, 1'b0);
        ram[2] = make_rec(200, 100, 3, 1'b1, 1'b1);
        apply_stimulus(3, -1, -1);
        check_output("three_plots", 32'(plots_seen), 32'd512);

        $display("[TB] corner clipping");
        ram[0] = make_rec(310, 230, 0, 1'b1, 1'b0);
        apply_stimulus(1, -1, -1);
        check_output("clip_plots", 32'(plots_seen), 32'd100);
        ram[0] = make_rec(304, 224, 1, 1'b1, 1'b0);
        apply_stimulus(1, -1, -1);
        check_output("edge_plots", 32'(plots_seen), 32'd256);

        $display("[TB] empty table");
        apply_stimulus(0, -1, -1);
        check_output("empty_plots", 32'(plots_seen), 32'd0);

        $display("[TB] start re-pulsed mid pass");
        ram[0] = make_rec(5, 5, 2, 1'b1, 1'b0);
        ram[1] = make_rec(40, 9, 0, 1'b1, 1'b0);
        apply_stimulus(2, 120, -1);

        $display("[TB] reset during draw");
        ram[0] = make_rec(150, 150, 1, 1'b1, 1'b0);
        ram[1] = make_rec(10, 10, 0, 1'b1, 1'b0);
        apply_stimulus(2, -1, 40);
        ram[0] = make_rec(77, 33, 3, 1'b1, 1'b0);
        apply_stimulus(1, -1, -1);

        $display("[TB] random tables");
        for (int k = 0; k < 5; k++) begin
            int q;
            q = $urandom_range(1, 3);
            for (int i = 0; i < 16; i++) begin
                ram[i] = make_rec($urandom_range(0, 511), $urandom_range(0, 255),
                                  $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                                  1'($urandom_range(0, 1)));
            end
            apply_stimulus(q, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
